// File: rtl/gpio_input_ctrl_if.sv
// ---------------------------------------------------------------------------
// gpio_input_ctrl_if
//   CPU data-bus connection for the GPIO input peripheral.
//
//   cs     : bus select for this peripheral
//   we     : write enable, qualified by cs
//   addr   : word offset (byte address bits [3:2])
//   wdata  : write data
//   rdata  : combinational read data (0 unless cs & ~we)
//   irq    : level interrupt request
//
//   master : the CPU / bus fabric side
//   slave  : the peripheral side
// ---------------------------------------------------------------------------
interface gpio_input_ctrl_if;
    logic        cs;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output cs, we, addr, wdata,
        input  rdata, irq
    );

    modport slave (
        input  cs, we, addr, wdata,
        output rdata, irq
    );
endinterface

// File: rtl/gpio_input_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_input_ctrl
//   Memory-mapped input peripheral. Every raw board input is passed through a
//   two-flop synchronizer and a per-bit debounce counter. Rising edges of the
//   debounced buttons are latched as pending events, which can raise a level
//   interrupt when enabled.
//
//   Ports
//     clk     : system clock
//     reset   : synchronous, active-high reset
//     btn_in  : raw button levels (asynchronous, active-high)
//     sw_in   : raw switch levels (asynchronous)
//     bus     : CPU bus slave (cs/we/addr/wdata in, rdata/irq out)
//
//   Register map (word offsets, unused bits read 0)
//     0 SW   : debounced switches, read-only
//     1 BTN  : debounced buttons, read-only
//     2 PEND : pending button presses, write-one-to-clear
//     3 IEN  : interrupt enable per button, read/write
// ---------------------------------------------------------------------------
module gpio_input_ctrl #(
    parameter int N_BTN           = 3,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_SW-1:0]  sw_in,
    gpio_input_ctrl_if.slave bus
);

    localparam int               N_IN    = N_BTN + N_SW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Input vector layout: buttons in the low bits, switches above them.
    logic [N_IN-1:0]  r_sync1;
    logic [N_IN-1:0]  r_sync2;
    logic [N_IN-1:0]  r_stable;
    logic [CNT_W-1:0] r_cnt [N_IN];
    logic [N_BTN-1:0] r_pending;
    logic [N_BTN-1:0] r_irq_en;
    logic             r_irq;

    logic [N_IN-1:0]  w_stable_nxt;
    logic [N_BTN-1:0] w_btn_rise;
    logic [N_BTN-1:0] w_pend_clr;
    logic             w_wr;
    logic             w_rd;
    logic [31:0]      w_rdata;
    logic             w_unused_wdata;

    assign w_wr = bus.cs & bus.we;
    assign w_rd = bus.cs & ~bus.we;

    // A bit accepts its synchronized level once it has disagreed with the
    // stable value for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_stable_nxt = r_stable;
        for (int i = 0; i < N_IN; i++) begin
            if ((r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX)) begin
                w_stable_nxt[i] = r_sync2[i];
            end
        end
    end

    // Press events are taken from the next-state value so pending sets on
    // the same edge the debounced button goes high.
    assign w_btn_rise = w_stable_nxt[N_BTN-1:0] & ~r_stable[N_BTN-1:0];
    assign w_pend_clr = (w_wr && (bus.addr == 2'd2)) ? bus.wdata[N_BTN-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_stable  <= '0;
            r_pending <= '0;
            r_irq_en  <= '0;
            r_irq     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_sync1   <= {sw_in, btn_in};
            r_sync2   <= r_sync1;
            r_stable  <= w_stable_nxt;
            // Set has priority over a simultaneous write-one-to-clear.
            r_pending <= (r_pending & ~w_pend_clr) | w_btn_rise;
            if (w_wr && (bus.addr == 2'd3)) begin
                r_irq_en <= bus.wdata[N_BTN-1:0];
            end
            r_irq     <= |(r_pending & r_irq_en);
        end
    end

    // Counters clear on agreement and on acceptance, so they never pass
    // CNT_MAX and never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the counter array is plain flops, not RAM, so it is reset like any other state.
            for (int i = 0; i < N_IN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if ((r_sync2[i] != r_stable[i]) && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // Reads are side-effect free and show the pre-edge register contents.
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (bus.addr)
                2'd0:    w_rdata[N_SW-1:0]  = r_stable[N_IN-1:N_BTN];
                2'd1:    w_rdata[N_BTN-1:0] = r_stable[N_BTN-1:0];
                2'd2:    w_rdata[N_BTN-1:0] = r_pending;
                default: w_rdata[N_BTN-1:0] = r_irq_en;
            endcase
        end
    end

    assign bus.rdata = w_rdata;
    assign bus.irq   = r_irq;

    // Upper write-data bits have no register behind them.
    assign w_unused_wdata = ^bus.wdata[31:N_BTN];

endmodule

// File: tb/tb_gpio_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpio_input_ctrl
//   Self-checking bench for gpio_input_ctrl with DEBOUNCE_CYCLES = 4.
//   Directed scenarios check fixed expected values; a randomized phase is
//   compared against a reference model that accepts a level once the last
//   DEBOUNCE_CYCLES synchronized samples all agree on it.
//   Inputs change on the falling edge; outputs are sampled shortly after it.
// ---------------------------------------------------------------------------
module tb_gpio_input_ctrl;

    localparam int N_BTN = 3;
    localparam int N_SW  = 10;
    localparam int N_IN  = N_BTN + N_SW;
    localparam int DEB   = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N_BTN-1:0] btn_in = '0;
    logic [N_SW-1:0]  sw_in = '0;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_input_ctrl_if bus();

    gpio_input_ctrl #(
        .N_BTN           (N_BTN),
        .N_SW            (N_SW),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CNT_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_in (btn_in),
        .sw_in  (sw_in),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [N_IN-1:0]             m_d1 = '0;
    logic [N_IN-1:0]             m_d2 = '0;
    logic [DEB-2:0][N_IN-1:0]    m_hist = '0;
    logic [N_IN-1:0]             m_stable = '0;
    logic [N_BTN-1:0]            m_pend = '0;
    logic [N_BTN-1:0]            m_ien = '0;
    logic                        m_irq = 1'b0;

    // Level accepted when the current sample and the previous DEB-1 samples
    // are all 1 (accept 1) or all 0 (accept 0); otherwise keep the old level.
    function automatic logic [N_IN-1:0] accept_level(input logic [N_IN-1:0] cur,
                                                     input logic [N_IN-1:0] smp,
                                                     input logic [DEB-2:0][N_IN-1:0] h);
        logic [N_IN-1:0] all1;
        logic [N_IN-1:0] all0;
        all1 = smp;
        all0 = ~smp;
        for (int i = 0; i < DEB - 1; i++) begin
            all1 = all1 & h[i];
            all0 = all0 & ~h[i];
        end
        return (cur | all1) & ~all0;
    endfunction

    always @(posedge clk) begin
        logic [N_IN-1:0]  ns;
        logic [N_BTN-1:0] clr;
        if (reset) begin
            m_d1     <= '0;
            m_d2     <= '0;
            m_hist   <= '0;
            m_stable <= '0;
            m_pend   <= '0;
            m_ien    <= '0;
            m_irq    <= 1'b0;
        end else begin
            ns  = accept_level(m_stable, m_d2, m_hist);
            clr = (bus.cs && bus.we && bus.addr == 2'd2) ? bus.wdata[N_BTN-1:0] : '0;
            m_d1     <= {sw_in, btn_in};
            m_d2     <= m_d1;
            m_hist   <= {m_hist[DEB-3:0], m_d2};
            m_stable <= ns;
            m_pend   <= (m_pend & ~clr) | (ns[N_BTN-1:0] & ~m_stable[N_BTN-1:0]);
            if (bus.cs && bus.we && bus.addr == 2'd3) m_ien <= bus.wdata[N_BTN-1:0];
            m_irq    <= (m_pend & m_ien) != '0;
        end
    end

    function automatic logic [31:0] model_rdata();
        logic [31:0] r;
        r = '0;
        if (bus.cs && !bus.we) begin
            case (bus.addr)
                2'd0:    r = 32'(m_stable[N_IN-1:N_BTN]);
                2'd1:    r = 32'(m_stable[N_BTN-1:0]);
                2'd2:    r = 32'(m_pend);
                default: r = 32'(m_ien);
            endcase
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_idle();
        bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = '0;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a; bus.wdata = '0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        sw_in = 10'h3FF; btn_in = 3'b111;
        bus_idle();
        apply_reset(3);
        for (int k = 1; k <= 5; k++) begin
            tick();
            for (int a = 0; a < 4; a++) begin
                bus_rd(2'(a));
                #1;
                n_tests++;
                if (bus.rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL reset_rd edge=%0d off=%0d: got %h expected 00000000", k, a, bus.rdata);
                end
            end
            bus_idle();
            n_tests++;
            if (bus.irq !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_irq edge=%0d: got %b expected 0", k, bus.irq);
            end
        end
        sw_in = '0; btn_in = '0;
        apply_reset(3);
    endtask

    task automatic test_sw_latency();
        logic [31:0] exp;
        sw_in = 10'h2A5;
        for (int k = 1; k <= 6; k++) begin
            tick();
            bus_rd(2'd0);
            #1;
            exp = (k >= 6) ? 32'h2A5 : 32'h0;
            n_tests++;
            if (bus.rdata !== exp) begin
                n_fail++;
                $display("FAIL sw_latency edge=%0d: got %h expected %h", k, bus.rdata, exp);
            end
        end
        bus_idle();
    endtask

    task automatic test_glitch();
        for (int k = 1; k <= 11; k++) begin
            btn_in[1] = (k <= 3);
            bus_idle();
            tick();
            bus_rd(2'd1);
            #1;
            n_tests++;
            if (bus.rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL glitch_btn edge=%0d: got %h expected 00000000", k, bus.rdata);
            end
            bus_rd(2'd2);
            #1;
            n_tests++;
            if (bus.rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL glitch_pend edge=%0d: got %h expected 00000000", k, bus.rdata);
            end
            n_tests++;
            if (bus.irq !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_irq edge=%0d: got %b expected 0", k, bus.irq);
            end
        end
        bus_idle();
    endtask

    task automatic test_press_irq();
        bus_wr(2'd3, 32'h2);
        tick();
        bus_rd(2'd3);
        #1;
        n_tests++;
        if (bus.rdata !== 32'h2) begin
            n_fail++;
            $display("FAIL ien_readback: got %h expected 00000002", bus.rdata);
        end
        for (int k = 1; k <= 20; k++) begin
            btn_in[1] = (k <= 10);
            if (k == 8) bus_wr(2'd2, 32'h2);
            else        bus_idle();
            tick();
            if (k == 6) begin
                bus_rd(2'd1);
                #1;
                n_tests++;
                if (bus.rdata !== 32'h2) begin
                    n_fail++;
                    $display("FAIL press_btn edge=6: got %h expected 00000002", bus.rdata);
                end
            end
            if (k == 6 || k == 7 || k == 8 || k == 20) begin
                bus_rd(2'd2);
                #1;
                n_tests++;
                if (bus.rdata !== ((k == 6 || k == 7) ? 32'h2 : 32'h0)) begin
                    n_fail++;
                    $display("FAIL press_pend edge=%0d: got %h expected %h", k, bus.rdata,
                             (k == 6 || k == 7) ? 32'h2 : 32'h0);
                end
            end
            if (k >= 6 && k <= 9) begin
                n_tests++;
                if (bus.irq !== (k == 7 || k == 8)) begin
                    n_fail++;
                    $display("FAIL press_irq edge=%0d: got %b expected %b", k, bus.irq, (k == 7 || k == 8));
                end
            end
            if (k == 20) begin
                bus_rd(2'd1);
                #1;
                n_tests++;
                if (bus.rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL release_btn: got %h expected 00000000", bus.rdata);
                end
                n_tests++;
                if (bus.irq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL release_irq: got %b expected 0", bus.irq);
                end
            end
        end
        bus_idle();
    endtask

    task automatic test_collision();
        for (int k = 1; k <= 7; k++) begin
            btn_in[0] = 1'b1;
            if (k == 6 || k == 7) bus_wr(2'd2, 32'h1);
            else                  bus_idle();
            tick();
            bus_rd(2'd2);
            #1;
            if (k == 6) begin
                n_tests++;
                if (bus.rdata !== 32'h1) begin
                    n_fail++;
                    $display("FAIL collision_pend: got %h expected 00000001", bus.rdata);
                end
            end
            if (k == 7) begin
                n_tests++;
                if (bus.rdata !== 32'h0) begin
                    n_fail++;
                    $display("FAIL w1c_pend: got %h expected 00000000", bus.rdata);
                end
            end
        end
        btn_in[0] = 1'b0;
        bus_idle();
        repeat (8) tick();
    endtask

    task automatic test_reset_mid();
        sw_in = '0;
        repeat (8) tick();
        sw_in[0] = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus_rd(2'd0);
            #1;
            n_tests++;
            if (bus.rdata[0] !== (k >= 6)) begin
                n_fail++;
                $display("FAIL reset_mid edge=%0d: got %b expected %b", k, bus.rdata[0], (k >= 6));
            end
        end
        bus_idle();
    endtask

    task automatic test_random();
        logic [N_IN-1:0] raw;
        int              r;
        logic [31:0]     exp;
        int              errs;
        errs = 0;
        sw_in = '0; btn_in = '0;
        bus_idle();
        apply_reset(2);
        for (int c = 0; c < 3000; c++) begin
            raw = {sw_in, btn_in};
            if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, N_IN - 1)] ^= 1'b1;
            {sw_in, btn_in} = raw;
            r = $urandom_range(0, 9);
            if (r <= 5)      bus_rd(2'($urandom_range(0, 3)));
            else if (r <= 7) bus_wr(2'($urandom_range(0, 3)), $urandom);
            else             bus_idle();
            #1;
            exp = model_rdata();
            n_tests++;
            if (bus.rdata !== exp) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_rdata cyc=%0d off=%0d: got %h expected %h", c, bus.addr, bus.rdata, exp);
            end
            n_tests++;
            if (bus.irq !== m_irq) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL rand_irq cyc=%0d: got %b expected %b", c, bus.irq, m_irq);
            end
            tick();
        end
        bus_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_idle();
        @(negedge clk);
        test_reset();
        test_sw_latency();
        test_glitch();
        test_press_irq();
        test_collision();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_input_ctrl.md
Name: gpio_input_ctrl

Overview:
- Memory-mapped input peripheral inside the RV32I system. It receives the raw board inputs (BUTTON[2:0] and SW[9:0]) that the system bench or board drives.
- Synchronizes and debounces every input bit, detects button presses, and latches them as pending events.
- Exposes status, pending and enable registers to the CPU data bus, plus a level interrupt request.

Parameters:
- N_BTN, 3, number of button inputs.
- N_SW, 10, number of switch inputs.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a new level (1 ms at 50 MHz); must be ≥2.
- CNT_W, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset  input  1  synchronous, active-high reset.
- btn_in  input  N_BTN  raw button levels, asynchronous, already active-high.
- sw_in  input  N_SW  raw switch levels, asynchronous.
- cs  input  1  bus select for this peripheral.
- we  input  1  write enable; qualified by cs.
- addr  input  2  word offset (byte address bits [3:2]).
- wdata  input  32  write data.
- rdata  output  32  read data.
- irq  output  1  interrupt request, level.

Behaviour:
- Reset (synchronous, active-high, single clock):
  - Clears synchronizer flops, debounce counters, stable levels, pending[N_BTN-1:0] and irq_en[N_BTN-1:0].
  - Outputs: rdata=0, irq=0.
  - Reset asserted mid-debounce discards the partial count.
- Synchronizer: each of the N_BTN+N_SW bits passes through 2 flops (sync1→sync2). No logic sits between the two flops.
- Debounce, one independent counter per bit:
  - If sync2≠stable, the counter increments; otherwise it clears to 0.
  - On an edge where sync2≠stable and counter==DEBOUNCE_CYCLES-1, stable takes sync2 and the counter clears.
  - Any single cycle of agreement restarts the count, so a glitch shorter than DEBOUNCE_CYCLES cycles after synchronization is ignored.
  - Latency: a raw change first captured at edge 1 updates stable at edge DEBOUNCE_CYCLES+2.
- Press detect:
  - A rising transition of btn_stable[i] (registered previous value 0, new value 1) sets pending[i] on the same edge that stable changes.
  - Release does not set pending.
- Register map (32-bit words, unused bits read 0):
  - 0 SW: sw_stable, read-only.
  - 1 BTN: btn_stable, read-only.
  - 2 PEND: pending. Write-one-to-clear: each wdata bit=1 clears the corresponding pending bit.
  - 3 IEN: irq_en, read/write on bits [N_BTN-1:0].
- Writes take effect at the clock edge where cs&we. Writes to offsets 0 and 1 are ignored.
- Simultaneous set and W1C clear of the same pending bit in one cycle: set wins, bit stays 1.
- Reads are combinational from the registered state:
  - rdata = selected register when cs&~we, else 0.
  - A read returns pre-edge values and has no side effects.
- irq = |(pending & irq_en), registered. It is asserted the cycle after the contributing pending/enable bits update and deasserts likewise.
- Counters saturate by design: they never exceed DEBOUNCE_CYCLES-1, so there is no wrap-around.

Test Plan:
Bench sets DEBOUNCE_CYCLES=4; edge numbering starts at 1 for the first edge after the raw input change.
- Reset: hold reset 3 cycles with sw_in=10'h3FF and btn_in=3'b111 → after release, rdata=0 for reads of offsets 0–3 during the first 5 edges, and irq=0.
- Switch latency: sw_in 0→10'h2A5 → offset 0 reads 0 after edge 5 and 0x2A5 after edge 6.
- Glitch reject: btn_in[1] high for exactly 3 post-sync cycles, then low → BTN and PEND read 0 and irq stays 0.
- Press and interrupt: write IEN=0x2, then hold btn_in[1] high 10 cycles →
  - BTN=0x2 and PEND=0x2 at edge 6;
  - irq=1 one cycle later;
  - write PEND=0x2 → PEND=0 and irq=0 the following cycle.
- Set vs clear collision: align a W1C write of 0x1 with the edge where btn_stable[0] rises → PEND bit0=1 afterwards.
- Reset mid-debounce: raise sw_in[0], assert reset at edge 4, deassert it, keep sw_in[0]=1 → SW bit0 becomes 1 only 6 edges after reset release, never earlier.
